// File: rtl/neuron_mac_engine.sv
// Fully-connected layer engine: LANES output neurons per pass, weights fetched as one
// LANES-wide BRAM word per activation. Optional macro RELU_EN clamps negative results to 0.
module neuron_mac_engine #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int LANES  = 16,
  parameter int ACC_W  = 40,
  parameter int ADDR_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      CPUEnable,
  input  logic                      busrdwr,
  input  logic [DATA_W-1:0]         data_bus,
  input  logic [DATA_W-1:0]         DRAMdata,
  input  logic                      DVAL,
  output logic                      SRAM_RdReq,
  output logic [ADDR_W-1:0]         BRAM_Addr_In,
  input  logic [LANES*DATA_W-1:0]   BRAM_data,
  output logic [DATA_W-1:0]         output_neuron,
  output logic [ADDR_W-1:0]         out_addr_current,
  output logic                      Wr_BRAM_current,
  output logic                      cpu_neuron_done
);

  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [DATA_W-1:0] LANES_D = DATA_W'(LANES);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic [2:0]                r_cfg_cnt;
  logic [DATA_W-1:0]         r_in_base, r_w_base, r_out_base, r_num_in, r_num_out;
  logic [DATA_W-1:0]         r_in_cnt, r_out_rem;
  logic [ADDR_W-1:0]         r_waddr, r_oaddr;
  logic [LANE_W-1:0]         r_lane;
  logic [DATA_W-1:0]         r_x;
  logic                      r_mac_vld;
  logic signed [ACC_W-1:0]   r_acc [LANES];
  logic signed [2*DATA_W-1:0] w_prod [LANES];

  logic w_cfg_wr, w_start, w_rd_req, w_accept, w_last_in, w_last_lane, w_more_pass, w_wr;
  logic [DATA_W-1:0] w_active;
  logic signed [ACC_W-1:0] w_shift;
  logic [DATA_W-1:0] w_result;
  logic w_unused;

  assign w_unused    = ^r_in_base;
  assign w_cfg_wr    = CPUEnable && busrdwr && (r_state == S_IDLE || r_state == S_CFG) && (r_cfg_cnt < 3'd5);
  assign w_start     = CPUEnable && (r_state == S_CFG) && !busrdwr && (r_cfg_cnt == 3'd5);
  assign w_rd_req    = CPUEnable && (r_state == S_RUN) && (r_in_cnt < r_num_in);
  assign w_accept    = w_rd_req && DVAL;
  assign w_last_in   = w_accept && ((r_in_cnt + DATA_W'(1)) == r_num_in);
  assign w_active    = (r_out_rem < LANES_D) ? r_out_rem : LANES_D;
  assign w_last_lane = ((DATA_W'(r_lane) + DATA_W'(1)) == w_active);
  assign w_more_pass = (r_out_rem > LANES_D);
  assign w_wr        = CPUEnable && (r_state == S_WRITE);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_prod[gi] = $signed(r_x) * $signed(BRAM_data[gi*DATA_W +: DATA_W]);
  end

  always_comb begin
    w_state_next = r_state;
    if (!CPUEnable) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (busrdwr) w_state_next = S_CFG;
        S_CFG:   if (w_start) w_state_next = (r_num_in == '0 || r_num_out == '0) ? S_DONE : S_RUN;
        S_RUN:   if (w_last_in) w_state_next = S_DRAIN;
        S_DRAIN: w_state_next = S_WRITE;
        S_WRITE: if (w_last_lane) w_state_next = w_more_pass ? S_RUN : S_DONE;
        S_DONE:  w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Arithmetic shift floors toward -inf; then clamp into the DATA_W signed range.
  always_comb begin
    w_shift  = r_acc[r_lane] >>> FRAC_W;
    w_result = w_shift[DATA_W-1:0];
    if (w_shift > SAT_MAX) w_result = SAT_MAX[DATA_W-1:0];
    else if (w_shift < SAT_MIN) w_result = SAT_MIN[DATA_W-1:0];
`ifdef RELU_EN
    if (w_result[DATA_W-1]) w_result = '0;
`else
    w_result = w_result;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cfg_cnt  <= '0;
      r_in_base  <= '0;
      r_w_base   <= '0;
      r_out_base <= '0;
      r_num_in   <= '0;
      r_num_out  <= '0;
      r_in_cnt   <= '0;
      r_out_rem  <= '0;
      r_waddr    <= '0;
      r_oaddr    <= '0;
      r_lane     <= '0;
      r_x        <= '0;
      r_mac_vld  <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_mac_vld <= w_accept;
      if (!CPUEnable || r_state == S_DONE) begin
        r_cfg_cnt <= '0;
      end else if (w_cfg_wr) begin
        case (r_cfg_cnt)
          3'd0:    r_in_base  <= data_bus;
          3'd1:    r_w_base   <= data_bus;
          3'd2:    r_out_base <= data_bus;
          3'd3:    r_num_in   <= data_bus;
          default: r_num_out  <= data_bus;
        endcase
        r_cfg_cnt <= r_cfg_cnt + 3'd1;
      end
      // Weight address runs continuously across passes: w_base + pass*num_in + i.
      if (w_start) begin
        r_in_cnt  <= '0;
        r_out_rem <= r_num_out;
        r_waddr   <= ADDR_W'(r_w_base);
        r_oaddr   <= ADDR_W'(r_out_base);
        r_lane    <= '0;
      end
      if (w_accept) begin
        r_in_cnt <= r_in_cnt + DATA_W'(1);
        r_waddr  <= r_waddr + ADDR_W'(1);
        r_x      <= DRAMdata;
      end
      if (w_wr) begin
        if (w_last_lane) begin
          r_lane    <= '0;
          r_in_cnt  <= '0;
          r_out_rem <= r_out_rem - LANES_D;
          r_oaddr   <= r_oaddr + ADDR_W'(LANES);
        end else begin
          r_lane <= r_lane + LANE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
    end else if (!CPUEnable || (w_wr && w_last_lane)) begin
      for (int k = 0; k < LANES; k++) r_acc[k] <= '0;
    end else if (r_mac_vld) begin
      for (int k = 0; k < LANES; k++) r_acc[k] <= r_acc[k] + ACC_W'(w_prod[k]);
    end
  end

  assign SRAM_RdReq       = w_rd_req;
  assign BRAM_Addr_In     = r_waddr;
  assign Wr_BRAM_current  = w_wr;
  assign out_addr_current = w_wr ? (r_oaddr + ADDR_W'(r_lane)) : '0;
  assign output_neuron    = w_wr ? w_result : '0;
  assign cpu_neuron_done  = CPUEnable && (r_state == S_DONE);

endmodule

// File: tb/tb_neuron_mac_engine.sv
// Scoreboard bench for neuron_mac_engine: FIFO/BRAM models feed the DUT, a reference
// model pushes expected writes, and a monitor pops and compares them.
module tb_neuron_mac_engine;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int LANES  = 16;
  localparam int ACC_W  = 40;
  localparam int ADDR_W = 16;

  logic clk = 1'b0;
  logic reset, CPUEnable, busrdwr, DVAL;
  logic [DATA_W-1:0] data_bus, DRAMdata;
  logic SRAM_RdReq, Wr_BRAM_current, cpu_neuron_done;
  logic [ADDR_W-1:0] BRAM_Addr_In, out_addr_current;
  logic [LANES*DATA_W-1:0] BRAM_data;
  logic [DATA_W-1:0] output_neuron;

  neuron_mac_engine #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .LANES(LANES), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .CPUEnable(CPUEnable), .busrdwr(busrdwr), .data_bus(data_bus),
    .DRAMdata(DRAMdata), .DVAL(DVAL), .SRAM_RdReq(SRAM_RdReq), .BRAM_Addr_In(BRAM_Addr_In),
    .BRAM_data(BRAM_data), .output_neuron(output_neuron), .out_addr_current(out_addr_current),
    .Wr_BRAM_current(Wr_BRAM_current), .cpu_neuron_done(cpu_neuron_done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } exp_t;
  exp_t sb_q[$];
  logic [DATA_W-1:0] act_q[$];
  int xs[$];
  logic [LANES*DATA_W-1:0] w_mem [64];

  int n_checks = 0, n_pass = 0;
  int cyc = 0, n_wr = 0, n_done = 0, n_req = 0, fifo_reads = 0;
  int last_acc_cyc = 0, done_cyc = 0, first_lat = -1;
  bit pend = 0, dval_toggle = 0, dval_phase = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    BRAM_data <= w_mem[BRAM_Addr_In[5:0]];
  end

  // Show-ahead FIFO: an item is consumed at the edge where SRAM_RdReq and DVAL are both high.
  initial begin
    DVAL = 1'b0;
    DRAMdata = '0;
    forever begin
      @(negedge clk);
      if (pend && act_q.size() > 0) begin
        void'(act_q.pop_front());
        fifo_reads++;
      end
      dval_phase = ~dval_phase;
      DVAL = (act_q.size() > 0) && (!dval_toggle || dval_phase);
      DRAMdata = (act_q.size() > 0) ? act_q[0] : '0;
      #1;
      pend = SRAM_RdReq && DVAL;
      if (pend) last_acc_cyc = cyc;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (Wr_BRAM_current) begin
        n_wr++;
        if (first_lat < 0) first_lat = cyc - last_acc_cyc;
        if (sb_q.size() == 0) begin
          check("unexpected_wr", 1, 0);
        end else begin
          e = sb_q.pop_front();
          $display("wr addr=0x%04h data=0x%04h exp_addr=0x%04h exp_data=0x%04h",
                   out_addr_current, output_neuron, e.addr, e.data);
          check("wr_addr", out_addr_current, e.addr);
          check("wr_data", output_neuron, e.data);
        end
      end
      if (cpu_neuron_done) begin
        n_done++;
        done_cyc = cyc;
      end
      if (SRAM_RdReq) n_req++;
    end
  end

  function automatic logic [DATA_W-1:0] sat_ref(input longint acc);
    longint s;
    logic [63:0] sv;
    s = acc >>> FRAC_W;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef RELU_EN
    if (s < 0) s = 0;
`endif
    sv = s;
    return sv[DATA_W-1:0];
  endfunction

  task automatic fill_w(input int base, input int n, input logic [DATA_W-1:0] wv);
    for (int j = 0; j < n; j++) w_mem[(base + j) & 63] = {LANES{wv}};
  endtask

  task automatic send_cfg(input int w_base, input int out_base, input int num_in, input int num_out);
    int words[5];
    words = '{0, w_base, out_base, num_in, num_out};
    @(negedge clk);
    CPUEnable = 1'b1;
    busrdwr = 1'b1;
    for (int j = 0; j < 5; j++) begin
      data_bus = DATA_W'(words[j]);
      @(negedge clk);
    end
    busrdwr = 1'b0;
  endtask

  task automatic run_layer(input int w_base, input int out_base, input int num_in, input int num_out,
                           input bit toggle, input string name);
    int passes, nact, exp_wr, start_cyc;
    longint acc;
    logic signed [DATA_W-1:0] xv, wv;
    exp_t e;
    passes = (num_in == 0 || num_out == 0) ? 0 : (num_out + LANES - 1) / LANES;
    exp_wr = 0;
    for (int p = 0; p < passes; p++) begin
      nact = (num_out - p*LANES < LANES) ? num_out - p*LANES : LANES;
      for (int k = 0; k < nact; k++) begin
        acc = 0;
        for (int i = 0; i < num_in; i++) begin
          xv = DATA_W'(xs[i]);
          wv = w_mem[(w_base + p*num_in + i) & 63][k*DATA_W +: DATA_W];
          acc += longint'(xv) * longint'(wv);
        end
        e.addr = ADDR_W'(out_base + p*LANES + k);
        e.data = sat_ref(acc);
        sb_q.push_back(e);
        exp_wr++;
      end
      for (int i = 0; i < num_in; i++) act_q.push_back(DATA_W'(xs[i]));
    end
    n_wr = 0; n_done = 0; n_req = 0; fifo_reads = 0; first_lat = -1;
    dval_toggle = toggle;
    send_cfg(w_base, out_base, num_in, num_out);
    start_cyc = cyc;
    for (int t = 0; t < 3000 && n_done == 0; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    $display("run %s: writes=%0d done=%0d fifo_reads=%0d", name, n_wr, n_done, fifo_reads);
    check({name, "_done"}, n_done, 1);
    check({name, "_nwr"}, n_wr, exp_wr);
    check({name, "_reads"}, fifo_reads, passes * num_in);
    check({name, "_sb_left"}, sb_q.size(), 0);
    if (exp_wr > 0) check({name, "_latency"}, first_lat, 2);
    if (num_in == 0) begin
      check({name, "_done_cyc"}, done_cyc - start_cyc, 1);
      check({name, "_rdreq"}, n_req, 0);
    end
    sb_q.delete();
    act_q.delete();
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_rdreq"}, SRAM_RdReq, 0);
    check({name, "_wr"}, Wr_BRAM_current, 0);
    check({name, "_done"}, cpu_neuron_done, 0);
    check({name, "_out"}, output_neuron, 0);
    check({name, "_oaddr"}, out_addr_current, 0);
  endtask

  initial begin
    reset = 1'b0; CPUEnable = 1'b0; busrdwr = 1'b0; data_bus = '0;
    for (int j = 0; j < 64; j++) w_mem[j] = '0;
    repeat (3) @(negedge clk);
    #2;
    check_idle_outputs("reset");
    check("reset_baddr", BRAM_Addr_In, 0);
    @(negedge clk);
    reset = 1'b1;

    xs.delete();
    for (int i = 1; i <= 16; i++) xs.push_back(i);
    fill_w(16, 16, 16'h0100); run_layer(16'h10, 16'h11, 16, 1, 0, "w100");
    fill_w(16, 16, 16'h0080); run_layer(16'h10, 16'h11, 16, 1, 0, "w080");
    fill_w(16, 16, 16'h0040); run_layer(16'h10, 16'h11, 16, 1, 0, "w040");
    fill_w(16, 16, 16'h0100); run_layer(16'h10, 16'h11, 16, 1, 1, "toggle");

    xs.delete();
    for (int i = 0; i < 4; i++) xs.push_back(1);
    fill_w(32, 8, 16'h0100); run_layer(16'h20, 16'h30, 4, 20, 0, "twopass");

    xs.delete();
    for (int i = 0; i < 16; i++) xs.push_back(16'h7FFF);
    fill_w(16, 16, 16'h0100); run_layer(16'h10, 16'h40, 16, 1, 0, "satpos");
    fill_w(16, 16, 16'hFF00); run_layer(16'h10, 16'h40, 16, 1, 0, "satneg");

    xs.delete();
    for (int i = 0; i < 5; i++) xs.push_back($urandom_range(0, 600) - 300);
    for (int j = 56; j < 66; j++)
      for (int k = 0; k < LANES; k++)
        w_mem[j & 63][k*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, 2000) - 1000);
    run_layer(16'h38, 16'hFFF8, 5, 18, 1, "random");

    // Abort by CPUEnable mid-RUN, then by reset mid-RUN.
    xs.delete();
    for (int i = 1; i <= 16; i++) xs.push_back(i);
    fill_w(16, 16, 16'h0100);
    for (int i = 0; i < 16; i++) act_q.push_back(DATA_W'(xs[i]));
    n_wr = 0; n_done = 0; dval_toggle = 0;
    send_cfg(16'h10, 16'h11, 16, 1);
    repeat (6) @(negedge clk);
    CPUEnable = 1'b0;
    @(negedge clk);
    CPUEnable = 1'b1;
    repeat (30) @(negedge clk);
    #2;
    check("abort_nwr", n_wr, 0);
    check("abort_ndone", n_done, 0);
    check_idle_outputs("abort");
    act_q.delete();
    for (int i = 0; i < 16; i++) act_q.push_back(DATA_W'(xs[i]));
    send_cfg(16'h10, 16'h11, 16, 1);
    repeat (6) @(negedge clk);
    reset = 1'b0;
    #2;
    check_idle_outputs("rstmid");
    @(negedge clk);
    reset = 1'b1;
    repeat (30) @(negedge clk);
    check("rstmid_nwr", n_wr, 0);
    check("rstmid_ndone", n_done, 0);
    act_q.delete();
    run_layer(16'h10, 16'h11, 16, 1, 0, "afterabort");

    run_layer(16'h10, 16'h11, 0, 1, 0, "numin0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
